chroni_vram: RTL and testbench

//  Video memory responder on the far end of chroni's text/font fetch port (addr_out -> vid_addr, vid_data -> data_in).

---
 rtl/chroni_vram_pkg.sv | 25 ++
 rtl/chroni_vram_req_fifo.sv | 55 +++++
 rtl/chroni_vram.sv | 142 ++++++++++++++
 tb/tb_chroni_vram.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chroni_vram_pkg.sv
// Shared definitions for the chroni video-memory responder: widths, queue entry
// layout {we, addr, wdata} and the CPU front-end state encoding.
package chroni_vram_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W     = 8;

    // Queue entry layout, LSB first: wdata, then addr, then the write flag on top.
    localparam int WDATA_LSB  = 0;
    localparam int ADDR_LSB   = DATA_W;

    typedef enum logic {
        FE_IDLE    = 1'b0,
        FE_RD_WAIT = 1'b1
    } fe_state_t;

    function automatic int entry_w(input int addr_w);
        return 1 + addr_w + DATA_W;
    endfunction

    function automatic int we_bit(input int addr_w);
        return addr_w + DATA_W;
    endfunction

endpackage

// File: rtl/chroni_vram_req_fifo.sv
// Synchronous FIFO holding queued CPU requests; head is visible combinationally
// so the arbiter can execute it in the same cycle it decides to pop.
module chroni_vram_req_fifo
    import chroni_vram_pkg::*;
#(
    parameter int WIDTH = entry_w(ADDR_W_DEF),
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full queue is still taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/chroni_vram.sv
// Video memory shared between chroni's fetch port and a queued CPU port: one RAM
// access per cycle, video first, with a starvation guard that forces CPU slots.
module chroni_vram
    import chroni_vram_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             vid_addr,
    output logic [7:0]                    vid_data,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [7:0]                    cpu_wdata,
    output logic                          cpu_ack,
    output logic [7:0]                    cpu_rdata,
    output logic                          cpu_full,
    output logic                          dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]   dbg_count
);

    // CPU handshake: the host raises cpu_req with stable we/addr/wdata and holds
    // it until a single-cycle cpu_ack; a request is taken only while cpu_ack=0 and
    // cpu_full=0, and cpu_rdata is meaningful only in the cpu_ack cycle of a read.

    localparam int E_W    = entry_w(ADDR_W);
    localparam int WE_BIT = we_bit(ADDR_W);
    localparam int CNT_W  = $clog2(STARVE_MAX + 1);

    logic [7:0]        ram [2**ADDR_W];
    logic [ADDR_W-1:0] vid_addr_q;
    logic [CNT_W-1:0]  starve_cnt;
    fe_state_t         state, state_d;

    logic [E_W-1:0]    head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              ack_d;
    logic              rd_exec;

    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [7:0]        head_wdata;
    logic              starved;
    logic              video_slot;
    logic              cpu_slot;
    logic              bypass;
    logic              req_seen;
    logic [ADDR_W-1:0] ram_addr;

    chroni_vram_req_fifo #(
        .WIDTH (E_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({cpu_we, cpu_addr, cpu_wdata}),
        .pop       (cpu_slot),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (dbg_count)
    );

    assign head_we    = head[WE_BIT];
    assign head_addr  = head[ADDR_LSB +: ADDR_W];
    assign head_wdata = head[WDATA_LSB +: DATA_W];

    // A saturated counter steals the slot even though the video address moved;
    // vid_addr_q is left alone so the video read retries next cycle.
    assign starved    = !fifo_empty && (starve_cnt == CNT_W'(STARVE_MAX));
    assign video_slot = (vid_addr != vid_addr_q) && !starved;
    assign cpu_slot   = !fifo_empty && !video_slot;
    assign bypass     = cpu_slot && head_we && (head_addr == vid_addr_q);
    assign ram_addr   = video_slot ? vid_addr : head_addr;

    assign cpu_full   = fifo_full;
    assign req_seen   = cpu_req && !cpu_ack && !fifo_full;
    assign dbg_state  = state;

    always_comb begin
        state_d = state;
        push    = 1'b0;
        ack_d   = 1'b0;
        rd_exec = 1'b0;
        case (state)
            FE_IDLE: begin
                if (req_seen) begin
                    push = 1'b1;
                    if (cpu_we)
                        ack_d = 1'b1;
                    else
                        state_d = FE_RD_WAIT;
                end
            end
            FE_RD_WAIT: begin
                // Nothing is accepted here, so a read at the head is this one.
                if (cpu_slot && !head_we) begin
                    rd_exec = 1'b1;
                    ack_d   = 1'b1;
                    state_d = FE_IDLE;
                end
            end
            default: state_d = FE_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (cpu_slot && head_we) ram[head_addr] <= head_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= FE_IDLE;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            vid_data   <= '0;
            vid_addr_q <= '1;
            starve_cnt <= '0;
        end else begin
            state   <= state_d;
            cpu_ack <= ack_d;
            if (rd_exec) cpu_rdata <= ram[ram_addr];
            // Writes to the displayed address refresh vid_data directly.
            if (video_slot)
                vid_data <= ram[ram_addr];
            else if (bypass)
                vid_data <= head_wdata;
            if (video_slot) vid_addr_q <= vid_addr;
            if (fifo_empty || cpu_slot)
                starve_cnt <= '0;
            else if (!starved)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_chroni_vram.sv
// Directed-plus-random bench for chroni_vram; a byte-array model of video memory
// supplies every expected value.
module tb_chroni_vram;

    localparam int ADDR_W     = 11;
    localparam int FIFO_DEPTH = 4;
    localparam int STARVE_MAX = 8;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] vid_addr;
    logic [7:0]        vid_data;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              cpu_full;
    logic              dbg_state;
    logic [CW-1:0]     dbg_count;

    chroni_vram #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_full  (cpu_full),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- reference model / scoreboard ----------------
    logic [7:0] mem_model [2**ADDR_W];
    bit         mem_known [2**ADDR_W];
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;
    bit         vid_run = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
        if (vid_run) vid_addr = vid_addr + 1'b1;
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [7:0] d, output int lat);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        lat       = 0;
        do begin
            tick();
            lat++;
        end while (!cpu_ack && lat < 50);
        check("wr_ack_seen", 32'(cpu_ack), 32'd1);
        cpu_req      = 1'b0;
        mem_model[a] = d;
        mem_known[a] = 1'b1;
    endtask

    task automatic cpu_read(input logic [ADDR_W-1:0] a, output logic [7:0] d, output int lat);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = a;
        lat      = 0;
        do begin
            tick();
            lat++;
        end while (!cpu_ack && lat < 200);
        check("rd_ack_seen", 32'(cpu_ack), 32'd1);
        d       = cpu_rdata;
        cpu_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [ADDR_W-1:0] ra;
    logic [7:0]        rd;
    logic [7:0]        dv;
    logic [7:0]        old_v;
    logic [7:0]        fw [4];
    int                lat;
    bit                ack_seen;
    localparam logic [ADDR_W-1:0] SBASE = 11'h200;

    initial begin
        reset     = 1'b1;
        vid_addr  = '1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) tick();

        check("rst_vid_data",  32'(vid_data),  32'h0);
        check("rst_cpu_ack",   32'(cpu_ack),   32'h0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("rst_cpu_full",  32'(cpu_full),  32'h0);
        check("rst_count",     32'(dbg_count), 32'h0);
        check("rst_state",     32'(dbg_state), 32'h0);
        reset = 1'b0;
        tick();
        // Video address equals the all-ones reset value: no video slot.
        check("idle_vid_data", 32'(vid_data), 32'h0);

        // Preload with the video address parked (every cycle is a CPU slot).
        for (int a = 16; a < 32; a++) begin
            cpu_write(ADDR_W'(a), 8'(a) ^ 8'h5A, lat);
            if (a == 16) check("wr_latency", 32'(lat), 32'd1);
        end
        cpu_write(11'h000, 8'h5A, lat);
        cpu_write(11'h600, 8'($urandom_range(0, 255)), lat);
        for (int k = 0; k < 12; k++)
            cpu_write(SBASE + ADDR_W'(k), 8'($urandom_range(0, 255)), lat);
        cpu_write(11'h7FF, 8'hA5, lat);
        tick();
        check("bypass_reset_addr", 32'(vid_data), 32'hA5);

        // Video-only: each address held 8 cycles, data visible one cycle after the change.
        for (int a = 16; a < 32; a++) begin
            vid_addr = ADDR_W'(a);
            tick();
            check("vid_lat1", 32'(vid_data), 32'(mem_model[a]));
            repeat (7) tick();
            check("vid_hold", 32'(vid_data), 32'(mem_model[a]));
        end

        // Address wrap is an ordinary change.
        vid_addr = 11'h7FF;
        tick();
        check("vid_top", 32'(vid_data), 32'(mem_model[11'h7FF]));
        vid_addr = 11'h000;
        tick();
        check("vid_wrap", 32'(vid_data), 32'(mem_model[0]));

        // CPU write then read back with the video address stable.
        cpu_write(11'h400, 8'hA5, lat);
        check("wr400_latency", 32'(lat), 32'd1);
        cpu_read(11'h400, rd, lat);
        check("rd400_data", 32'(rd), 32'hA5);
        check("rd400_within3", 32'(lat <= 3), 32'd1);
        tick();
        check("ack_pulse", 32'(cpu_ack), 32'd0);

        // Bypass: displayed address written by the CPU.
        vid_addr = 11'h010;
        tick();
        check("bypass_before", 32'(vid_data), 32'(mem_model[11'h010]));
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 11'h010;
        cpu_wdata = 8'h3C;
        tick();
        check("bypass_enq_ack", 32'(cpu_ack), 32'd1);
        check("bypass_not_yet", 32'(vid_data), 32'(mem_model[11'h010]));
        cpu_req = 1'b0;
        mem_model[11'h010] = 8'h3C;
        tick();
        check("bypass_exec", 32'(vid_data), 32'h3C);
        check("ack_one_cycle", 32'(cpu_ack), 32'd0);

        // Random CPU traffic with the video address parked on 0x010.
        for (int i = 0; i < 24; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 11'h010 : 11'h100 + ADDR_W'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1 || !mem_known[ra]) begin
                cpu_write(ra, 8'($urandom_range(0, 255)), lat);
            end else begin
                exp_q.push_back(mem_model[ra]);
                cpu_read(ra, rd, lat);
                check("rand_rd", 32'(rd), 32'(exp_q.pop_front()));
            end
        end
        repeat (2) tick();
        check("rand_vid_sync", 32'(vid_data), 32'(mem_model[11'h010]));

        // Random video fetches over preloaded addresses.
        for (int i = 0; i < 10; i++) begin
            ra = ADDR_W'($urandom_range(16, 31));
            vid_addr = ra;
            repeat (2) tick();
            check("rand_vid", 32'(vid_data), 32'(mem_model[ra]));
        end

        // Starvation: video address changes every cycle; a queued write must win
        // on the 9th cycle after enqueue, and the deferred video read lands a cycle late.
        dv = ~mem_model[SBASE + 11'd8];
        vid_addr  = SBASE;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = SBASE + 11'd8;
        cpu_wdata = dv;
        tick();
        check("starve_enq_ack", 32'(cpu_ack), 32'd1);
        check("starve_vid0", 32'(vid_data), 32'(mem_model[SBASE]));
        cpu_req = 1'b0;
        for (int k = 1; k <= STARVE_MAX; k++) begin
            vid_addr = SBASE + ADDR_W'(k);
            tick();
            check("starve_vid_k", 32'(vid_data), 32'(mem_model[SBASE + ADDR_W'(k)]));
        end
        mem_model[SBASE + 11'd8] = dv;
        vid_addr = SBASE + 11'd9;
        tick();
        check("starve_forced_exec", 32'(vid_data), 32'(dv));
        tick();
        check("starve_vid_lat2", 32'(vid_data), 32'(mem_model[SBASE + 11'd9]));

        // Full / ordering with the video address moving every cycle.
        vid_addr = 11'h300;
        vid_run  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fw[i] = 8'($urandom_range(0, 255));
            cpu_write(11'h500, fw[i], lat);
            if (i == 2) check("not_full_3", 32'(cpu_full), 32'd0);
        end
        check("full_after_4", 32'(cpu_full), 32'd1);
        check("count_4", 32'(dbg_count), 32'(FIFO_DEPTH));
        exp_q.push_back(mem_model[11'h500]);
        cpu_read(11'h500, rd, lat);
        check("order_rd", 32'(rd), 32'(exp_q.pop_front()));
        check("order_rd_last", 32'(rd), 32'(fw[3]));

        // Reset while a read waits behind a starved write: both are dropped.
        old_v = mem_model[11'h600];
        cpu_write(11'h600, ~old_v, lat);
        mem_model[11'h600] = old_v;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 11'h600;
        repeat (4) tick();
        check("rd_wait_state", 32'(dbg_state), 32'd1);
        reset    = 1'b1;
        cpu_req  = 1'b0;
        vid_run  = 1'b0;
        vid_addr = '1;
        tick();
        reset = 1'b0;
        check("mid_rst_vid_data",  32'(vid_data),  32'h0);
        check("mid_rst_cpu_ack",   32'(cpu_ack),   32'h0);
        check("mid_rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("mid_rst_cpu_full",  32'(cpu_full),  32'h0);
        check("mid_rst_count",     32'(dbg_count), 32'h0);
        check("mid_rst_state",     32'(dbg_state), 32'h0);
        ack_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_ack) ack_seen = 1'b1;
        end
        check("no_ack_after_rst", 32'(ack_seen), 32'd0);
        check("vid_after_rst", 32'(vid_data), 32'h0);
        cpu_read(11'h600, rd, lat);
        check("dropped_write", 32'(rd), 32'(old_v));
        check("blank_rd_lat", 32'(lat), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
